// File: rtl/sdf_channel_fifo.sv
// Single-clock token FIFO used as the channel between two dataflow actors.
// Flags are decoded from the registered count only, so no input reaches an output combinationally.
module sdf_channel_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf_err,
  output logic                  udf_err,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  // A single-entry FIFO keeps both pointers pinned at 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge ck) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error event in the same cycle as clr_err keeps the flag set.
      ovf_err <= (wr & ~wr_acc) | (ovf_err & ~clr_err);
      udf_err <= (rd & empty)   | (udf_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sdf_channel_fifo.sv
// Directed bench for sdf_channel_fifo (WIDTH=32, DEPTH=8): ordering, flags, wrap, errors, reset.
module tb_sdf_channel_fifo;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty, ovf_err, udf_err;

  int checks = 0;
  int errors = 0;

  sdf_channel_fifo #(.WIDTH(32), .DEPTH_LOG2(3)) dut (
    .ck(ck), .rst(rst),
    .wr(wr), .wr_data(wr_data), .full(full),
    .rd(rd), .rd_data(rd_data), .empty(empty),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .ovf_err(ovf_err), .udf_err(udf_err), .clr_err(clr_err)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  initial begin
    int src, acc, nacc;
    int outs[$];
    logic rd_prev;

    // reset values
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_udf", udf_err, 0);
    #1 rst = 1'b0;
    tick;

    // three writes then three reads
    wr = 1; wr_data = 32'h11; tick; chk("t1_cnt1", count, 1);
    wr_data = 32'h22; tick; chk("t1_cnt2", count, 2);
    chk("t1_ae2", almost_empty, 0);
    wr_data = 32'h33; tick; chk("t1_cnt3", count, 3);
    wr = 0; rd = 1;
    tick; chk("t1_rd11", rd_data, 32'h11); chk("t1_cnt_r1", count, 2);
    tick; chk("t1_rd22", rd_data, 32'h22); chk("t1_cnt_r2", count, 1);
    tick; chk("t1_rd33", rd_data, 32'h33); chk("t1_cnt_r3", count, 0);
    rd = 0;
    chk("t1_empty", empty, 1);
    tick; chk("t1_hold", rd_data, 32'h33);
    chk("t1_ovf", ovf_err, 0);
    chk("t1_udf", udf_err, 0);

    // fill to full, almost_full from 7, overflow drop
    for (int i = 0; i < 8; i++) begin
      wr = 1; wr_data = 32'hB0 + i; tick;
      chk("t2_cnt", count, i + 1);
      chk("t2_af", almost_full, (i + 1 >= 7) ? 1 : 0);
    end
    chk("t2_full", full, 1);
    wr_data = 32'hDEAD; tick; wr = 0;
    chk("t2_ovf", ovf_err, 1);
    chk("t2_cnt_ovf", count, 8);
    clr_err = 1; tick; clr_err = 0;
    chk("t2_clr", ovf_err, 0);

    // simultaneous rd/wr while full, then drain across the wrap
    wr = 1; rd = 1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA0 + i; tick;
      chk("t3_pass", rd_data, 32'hB0 + i);
      chk("t3_cnt", count, 8);
      chk("t3_full", full, 1);
    end
    wr = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t3_drain", rd_data, (i < 4) ? (32'hB4 + i) : (32'hA0 + i - 4));
    end
    rd = 0;
    chk("t3_empty", empty, 1);
    chk("t3_ovf", ovf_err, 0);

    // simultaneous rd/wr while empty: no bypass
    wr = 1; rd = 1; wr_data = 32'h55; tick; wr = 0; rd = 0;
    chk("t4_udf", udf_err, 1);
    chk("t4_cnt", count, 1);
    chk("t4_hold", rd_data, 32'hA3);
    rd = 1; tick; rd = 0;
    chk("t4_rd55", rd_data, 32'h55);
    chk("t4_cnt0", count, 0);
    clr_err = 1; rd = 1; tick; rd = 0;
    chk("t4_setwins", udf_err, 1);
    tick; clr_err = 0;
    chk("t4_clr", udf_err, 0);

    // source -> fifo -> 4:1 accumulator with random stalls
    src = 1; acc = 0; nacc = 0; rd_prev = 0;
    for (int cyc = 0; cyc < 600 && outs.size() < 2; cyc++) begin
      if (rd_prev) begin
        acc += int'(rd_data);
        nacc++;
        if (nacc == 4) begin outs.push_back(acc); acc = 0; nacc = 0; end
      end
      wr = (src <= 8) && !full && ($urandom_range(0, 3) != 0);
      wr_data = src;
      if (wr) src++;
      rd = !empty && ($urandom_range(0, 2) == 0);
      rd_prev = rd;
      tick;
    end
    wr = 0; rd = 0;
    chk("t5_nout", outs.size(), 2);
    chk("t5_out0", (outs.size() > 0) ? outs[0] : 0, 10);
    chk("t5_out1", (outs.size() > 1) ? outs[1] : 0, 26);
    chk("t5_ovf", ovf_err, 0);
    chk("t5_udf", udf_err, 0);

    // asynchronous reset mid-burst
    wr = 1;
    for (int i = 0; i < 5; i++) begin wr_data = 32'hC0 + i; tick; end
    chk("t6_cnt5", count, 5);
    wr_data = 32'h99;
    #3 rst = 1;
    #1;
    chk("t6_rcount", count, 0);
    chk("t6_rempty", empty, 1);
    chk("t6_rae", almost_empty, 1);
    chk("t6_rdata", rd_data, 0);
    #1 rst = 0; wr = 0;
    tick;
    wr = 1; wr_data = 32'h77; tick; wr = 0;
    chk("t6_cnt1", count, 1);
    rd = 1; tick; rd = 0;
    chk("t6_rd77", rd_data, 32'h77);
    rd = 1; tick; rd = 0;
    wr = 1;
    for (int i = 0; i < 9; i++) begin wr_data = 32'hE0 + i; tick; end
    wr = 0;
    chk("t6_udf", udf_err, 1);
    chk("t6_ovf", ovf_err, 1);
    clr_err = 1; tick; clr_err = 0;
    chk("t6_clr_udf", udf_err, 0);
    chk("t6_clr_ovf", ovf_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
